// File: rtl/pmem_responder_if.sv
// Physical-memory line interface between the L2 cache controller (master)
// and the main-memory responder (slave).
interface pmem_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output pmem_read,
        output pmem_write,
        output pmem_address,
        output pmem_wdata,
        input  pmem_rdata,
        input  pmem_resp
    );

    modport slave (
        input  pmem_read,
        input  pmem_write,
        input  pmem_address,
        input  pmem_wdata,
        output pmem_rdata,
        output pmem_resp
    );
endinterface

// File: rtl/pmem_responder.sv
// Main-memory responder for 256-bit line reads/writes.
// Serves one request at a time and pulses pmem_resp after a fixed latency.
// Also flags initiator protocol violations and counts completed accesses.
module pmem_responder #(
    parameter int unsigned LAT_READ   = 4,
    parameter int unsigned LAT_WRITE  = 4,
    parameter int unsigned DEPTH_LOG2 = 11
) (
    input  logic            clk,
    input  logic            rst,
    pmem_responder_if.slave bus,
    output logic            proto_err,
    output logic [15:0]     rd_count,
    output logic [15:0]     wr_count
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESPOND
    } state_t;

    typedef logic [DEPTH_LOG2-1:0] idx_t;

    state_t       state;
    logic         op_write;
    logic [15:0]  addr_q;
    logic [255:0] wdata_q;
    logic [7:0]   cnt;

    logic [255:0] mem [DEPTH];

    // Request decode. Address bits [4:0] are the line offset; upper bits alias.
    logic       req_one;
    logic       req_both;
    idx_t       req_idx;
    idx_t       lat_idx;
    logic [7:0] req_lat_m1;
    logic       req_mismatch;

    assign req_both   = bus.pmem_read & bus.pmem_write;
    assign req_one    = bus.pmem_read ^ bus.pmem_write;
    assign req_idx    = bus.pmem_address[5 +: DEPTH_LOG2];
    assign lat_idx    = addr_q[5 +: DEPTH_LOG2];
    assign req_lat_m1 = bus.pmem_write ? 8'(LAT_WRITE - 1) : 8'(LAT_READ - 1);

    // While an op is in flight the initiator must hold exactly the accepted
    // request; any drop, flip or address/wdata change is a violation.
    // Write data is irrelevant to reads and is not compared for them.
    assign req_mismatch = (bus.pmem_write != op_write)
                       || (bus.pmem_read == op_write)
                       || (bus.pmem_address != addr_q)
                       || (op_write && (bus.pmem_wdata != wdata_q));

    // Control FSM with registered outputs: resp and rdata are loaded on the
    // edge that enters RESPOND so they are valid throughout that cycle.
    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            op_write       <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt            <= '0;
            bus.pmem_resp  <= 1'b0;
            bus.pmem_rdata <= '0;
            proto_err      <= 1'b0;
            rd_count       <= '0;
            wr_count       <= '0;
        end else begin
            bus.pmem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_both) begin
                        proto_err <= 1'b1;
                    end else if (req_one) begin
                        op_write <= bus.pmem_write;
                        addr_q   <= bus.pmem_address;
                        wdata_q  <= bus.pmem_wdata;
                        cnt      <= req_lat_m1;
                        if (req_lat_m1 == 8'd0) begin
                            // Single-cycle latency: respond straight away.
                            state         <= RESPOND;
                            bus.pmem_resp <= 1'b1;
                            if (!bus.pmem_write) begin
                                bus.pmem_rdata <= mem[req_idx];
                            end
                        end else begin
                            state <= BUSY;
                        end
                    end
                end

                BUSY: begin
                    if (req_mismatch) begin
                        proto_err <= 1'b1;
                    end
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1) begin
                        state         <= RESPOND;
                        bus.pmem_resp <= 1'b1;
                        if (!op_write) begin
                            bus.pmem_rdata <= mem[lat_idx];
                        end
                    end
                end

                RESPOND: begin
                    if (req_mismatch) begin
                        proto_err <= 1'b1;
                    end
                    if (op_write) begin
                        if (wr_count != 16'hFFFF) begin
                            wr_count <= wr_count + 16'd1;
                        end
                    end else begin
                        if (rd_count != 16'hFFFF) begin
                            rd_count <= rd_count + 16'd1;
                        end
                    end
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Line storage: a write commits on the edge that closes its RESPOND cycle.
    // NOTE: the array deliberately has no reset so it maps onto block RAM;
    // its contents survive rst.
    always_ff @(posedge clk) begin
        if ((state == RESPOND) && op_write) begin
            mem[lat_idx] <= wdata_q;
        end
    end

endmodule
